// File: rtl/seq_multiplier_if.sv
// Operand/result bundle for seq_multiplier.
// master: the requester driving operands; slave: the multiplier itself.
interface seq_multiplier_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, optional signed
// operands handled as magnitudes plus a sign fix-up.
// Optional feature macro: EARLY_TERM_EN. When it is defined, RUN exits as soon
// as the remaining multiplier bits are all zero.
module seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  seq_multiplier_if.slave   mul
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic                 last_iter;
  logic                 mplier_empty;

  // Magnitudes; -2^(W-1) maps to 2^(W-1), which still fits unsigned in W bits.
  assign abs_a = (mul.signed_mode && mul.multiplicand[WIDTH-1]) ? -mul.multiplicand
                                                                 : mul.multiplicand;
  assign abs_b = (mul.signed_mode && mul.multiplier[WIDTH-1]) ? -mul.multiplier
                                                               : mul.multiplier;

  assign last_iter    = (count_q == CntW'(WIDTH - 1));
  assign mplier_empty = (mplier_q == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (mul.start) state_d = StRun;
      StRun: begin
`ifdef EARLY_TERM_EN
        if (mplier_empty || last_iter) state_d = StFix;
`else
        if (last_iter) state_d = StFix;
`endif
      end
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: busy is purely state-decoded; done comes from a register.
  always_comb begin
    mul.busy    = (state_q == StRun) || (state_q == StFix);
    mul.done    = done_q;
    mul.product = product_q;
  end

  // Datapath next-state: operand capture, shift-add iteration, sign fix-up.
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    neg_d     = neg_q;
    product_d = product_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mul.start) begin
          mcand_d  = {{WIDTH{1'b0}}, abs_a};
          mplier_d = abs_b;
          acc_d    = '0;
          count_d  = '0;
          neg_d    = mul.signed_mode & (mul.multiplicand[WIDTH-1] ^ mul.multiplier[WIDTH-1]);
        end
      end
      StRun: begin
`ifdef EARLY_TERM_EN
        if (!mplier_empty) begin
`else
        begin
`endif
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + 1'b1;
        end
      end
      StFix: begin
        product_d = neg_q ? -acc_q : acc_q;
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

endmodule
